// File: rtl/clock_alarm_core.sv
// BCD time-of-day clock with weekday, N independently enabled alarm slots and a
// timed buzzer. Buttons are one-cycle pulses from the debouncer.
module clock_alarm_core #(
  parameter int unsigned M_FREQ    = 1,
  parameter int unsigned N_ALARMS  = 4,
  parameter int unsigned BUZZ_SECS = 5
) (
  input  logic                mclk,
  input  logic                rst,
  input  logic [1:0]          clk_mode,
  input  logic [1:0]          vButton,
  input  logic [2:0]          alarm_sel,
  output logic [23:0]         bcd_time,
  output logic [2:0]          weekday,
  output logic [15:0]         alarm_bcd,
  output logic [N_ALARMS-1:0] alarm_en,
  output logic [N_ALARMS-1:0] alarm_hit,
  output logic                buzzer,
  output logic                tick_1hz
);

  localparam logic [1:0]  MODE_RUN   = 2'd0;
  localparam logic [1:0]  MODE_TIME  = 2'd1;
  localparam logic [1:0]  MODE_ALARM = 2'd2;
  localparam logic [1:0]  MODE_WDAY  = 2'd3;
  localparam logic [31:0] P_LAST     = 32'(M_FREQ - 1);
  localparam logic [7:0]  B_LOAD     = 8'(BUZZ_SECS);

  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc24(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [2:0] inc7(input logic [2:0] v);
    return (v == 3'd6) ? 3'd0 : v + 3'd1;
  endfunction

  logic [31:0]         pcnt_q, pcnt_d;
  logic [7:0]          hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [2:0]          wd_q, wd_d;
  logic [7:0]          al_hh_q [N_ALARMS];
  logic [7:0]          al_hh_d [N_ALARMS];
  logic [7:0]          al_mm_q [N_ALARMS];
  logic [7:0]          al_mm_d [N_ALARMS];
  logic [N_ALARMS-1:0] en_q, en_d, hit_q, hit_d;
  logic                buzz_q, buzz_d, tick_q;
  logic [7:0]          bcnt_q, bcnt_d;

  logic                tick;
  logic [N_ALARMS-1:0] sel_hit, match;
  logic [7:0]          nx_hh, nx_mm, nx_ss;
  logic [2:0]          nx_wd;
  logic                c_s, c_m, c_h;

  // One-hot slot decode; out-of-range selects decode to nothing.
  always_comb begin
    sel_hit   = '0;
    alarm_bcd = '0;
    for (int k = 0; k < N_ALARMS; k++) begin
      sel_hit[k] = (alarm_sel == 3'(k));
      if (sel_hit[k]) alarm_bcd = {al_hh_q[k], al_mm_q[k]};
    end
  end

  // Full seconds->weekday carry chain, resolved in one edge.
  always_comb begin
    nx_ss = inc60(ss_q);
    c_s   = (ss_q == 8'h59);
    nx_mm = c_s ? inc60(mm_q) : mm_q;
    c_m   = c_s && (mm_q == 8'h59);
    nx_hh = c_m ? inc24(hh_q) : hh_q;
    c_h   = c_m && (hh_q == 8'h23);
    nx_wd = c_h ? inc7(wd_q) : wd_q;
  end

  always_comb begin
    pcnt_d  = '0;
    tick    = 1'b0;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    wd_d    = wd_q;
    al_hh_d = al_hh_q;
    al_mm_d = al_mm_q;
    en_d    = en_q;
    match   = '0;
    buzz_d  = buzz_q;
    hit_d   = hit_q;
    bcnt_d  = bcnt_q;

    case (clk_mode)
      MODE_RUN: begin
        if (pcnt_q == P_LAST) tick = 1'b1;
        else                  pcnt_d = pcnt_q + 32'd1;
        if (tick) begin
          ss_d = nx_ss;
          mm_d = nx_mm;
          hh_d = nx_hh;
          wd_d = nx_wd;
        end
      end
      MODE_TIME: begin
        ss_d = 8'h00;
        if (vButton[0]) mm_d = inc60(mm_q);
        if (vButton[1]) hh_d = inc24(hh_q);
      end
      MODE_ALARM: begin
        for (int k = 0; k < N_ALARMS; k++) begin
          if (sel_hit[k] && vButton[0]) al_mm_d[k] = inc60(al_mm_q[k]);
          if (sel_hit[k] && vButton[1]) al_hh_d[k] = inc24(al_hh_q[k]);
        end
      end
      MODE_WDAY: begin
        if (vButton[0]) wd_d = inc7(wd_q);
        for (int k = 0; k < N_ALARMS; k++) begin
          if (sel_hit[k] && vButton[1]) en_d[k] = ~en_q[k];
        end
      end
      default: ;
    endcase

    for (int k = 0; k < N_ALARMS; k++) begin
      match[k] = tick && en_q[k] && (nx_hh == al_hh_q[k]) &&
                 (nx_mm == al_mm_q[k]) && (nx_ss == 8'h00);
    end

    // Silencing beats a simultaneous match; a match while buzzing reloads.
    if (clk_mode != MODE_RUN || (buzz_q && |vButton)) begin
      buzz_d = 1'b0;
      hit_d  = '0;
      bcnt_d = '0;
    end else if (|match) begin
      buzz_d = 1'b1;
      hit_d  = hit_q | match;
      bcnt_d = B_LOAD;
    end else if (tick && bcnt_q != 8'd0) begin
      bcnt_d = bcnt_q - 8'd1;
      if (bcnt_q == 8'd1) begin
        buzz_d = 1'b0;
        hit_d  = '0;
      end
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      pcnt_q <= '0;
      hh_q   <= '0;
      mm_q   <= '0;
      ss_q   <= '0;
      wd_q   <= '0;
      for (int k = 0; k < N_ALARMS; k++) begin
        al_hh_q[k] <= '0;
        al_mm_q[k] <= '0;
      end
      en_q   <= '0;
      hit_q  <= '0;
      buzz_q <= 1'b0;
      bcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      wd_q    <= wd_d;
      al_hh_q <= al_hh_d;
      al_mm_q <= al_mm_d;
      en_q    <= en_d;
      hit_q   <= hit_d;
      buzz_q  <= buzz_d;
      bcnt_q  <= bcnt_d;
      tick_q  <= tick;
    end
  end

  assign bcd_time  = {hh_q, mm_q, ss_q};
  assign weekday   = wd_q;
  assign alarm_en  = en_q;
  assign alarm_hit = hit_q;
  assign buzzer    = buzz_q;
  assign tick_1hz  = tick_q;

endmodule

// File: tb/tb_clock_alarm_core.sv
// Bench for clock_alarm_core with M_FREQ=3, N_ALARMS=4, BUZZ_SECS=5.
// Observed vector = {bcd_time, weekday, buzzer, alarm_hit, alarm_en, tick_1hz, alarm_bcd}.
module tb_clock_alarm_core;

  localparam int W = 53;

  logic        mclk = 1'b0;
  logic        rst;
  logic [1:0]  clk_mode;
  logic [1:0]  vButton;
  logic [2:0]  alarm_sel;
  logic [23:0] bcd_time;
  logic [2:0]  weekday;
  logic [15:0] alarm_bcd;
  logic [3:0]  alarm_en;
  logic [3:0]  alarm_hit;
  logic        buzzer;
  logic        tick_1hz;

  clock_alarm_core #(.M_FREQ(3), .N_ALARMS(4), .BUZZ_SECS(5)) dut (
    .mclk      (mclk),
    .rst       (rst),
    .clk_mode  (clk_mode),
    .vButton   (vButton),
    .alarm_sel (alarm_sel),
    .bcd_time  (bcd_time),
    .weekday   (weekday),
    .alarm_bcd (alarm_bcd),
    .alarm_en  (alarm_en),
    .alarm_hit (alarm_hit),
    .buzzer    (buzzer),
    .tick_1hz  (tick_1hz)
  );

  // clock / reset
  always #5 mclk = ~mclk;

  logic [W-1:0] obs;
  assign obs = {bcd_time, weekday, buzzer, alarm_hit, alarm_en, tick_1hz, alarm_bcd};

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [W-1:0] mk(input logic [23:0] t, input logic [2:0] wd,
                                      input logic b, input logic [3:0] h,
                                      input logic [3:0] e, input logic tk,
                                      input logic [15:0] ab);
    return {t, wd, b, h, e, tk, ab};
  endfunction

  task automatic expect_obs(input logic [W-1:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check_obs(input string name);
    logic [W-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: no expected entry queued, got %h", name, obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        n_errors++;
        $display("FAIL %s: got time=%h wd=%0d buz=%b hit=%b en=%b tick=%b abcd=%h, expected time=%h wd=%0d buz=%b hit=%b en=%b tick=%b abcd=%h",
                 name, obs[52:29], obs[28:26], obs[25], obs[24:21], obs[20:17], obs[16], obs[15:0],
                 e[52:29], e[28:26], e[25], e[24:21], e[20:17], e[16], e[15:0]);
      end
    end
  endtask

  // driver: hold inputs for n edges, sample #1 after the last edge
  task automatic run(input logic [1:0] mode, input logic [1:0] btn,
                     input logic [2:0] sel, input int n);
    clk_mode  = mode;
    vButton   = btn;
    alarm_sel = sel;
    repeat (n) @(posedge mclk);
    #1;
    vButton = 2'b00;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  btn;
    logic [2:0]  sel;
    int          ncyc;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // reset state
    rst = 1'b0; clk_mode = 2'd0; vButton = 2'b00; alarm_sel = 3'd0;
    repeat (2) @(posedge mclk);
    #1;
    expect_obs('0);
    check_obs("reset_state");
    rst = 1'b1;

    vecs[0]  = '{2'd0, 2'b00, 3'd0, 2, mk(24'h000000, 3'd0, 0, 4'b0000, 4'b0000, 0, 16'h0000)};
    vecs[1]  = '{2'd0, 2'b00, 3'd0, 1, mk(24'h000001, 3'd0, 0, 4'b0000, 4'b0000, 1, 16'h0000)};
    vecs[2]  = '{2'd0, 2'b00, 3'd0, 1, mk(24'h000001, 3'd0, 0, 4'b0000, 4'b0000, 0, 16'h0000)};
    vecs[3]  = '{2'd0, 2'b00, 3'd0, 5, mk(24'h000003, 3'd0, 0, 4'b0000, 4'b0000, 1, 16'h0000)};
    vecs[4]  = '{2'd1, 2'b00, 3'd0, 1, mk(24'h000000, 3'd0, 0, 4'b0000, 4'b0000, 0, 16'h0000)};
    vecs[5]  = '{2'd1, 2'b01, 3'd0, 1, mk(24'h000100, 3'd0, 0, 4'b0000, 4'b0000, 0, 16'h0000)};
    vecs[6]  = '{2'd1, 2'b10, 3'd0, 1, mk(24'h010100, 3'd0, 0, 4'b0000, 4'b0000, 0, 16'h0000)};
    vecs[7]  = '{2'd1, 2'b11, 3'd0, 1, mk(24'h020200, 3'd0, 0, 4'b0000, 4'b0000, 0, 16'h0000)};
    vecs[8]  = '{2'd2, 2'b11, 3'd1, 1, mk(24'h020200, 3'd0, 0, 4'b0000, 4'b0000, 0, 16'h0101)};
    vecs[9]  = '{2'd2, 2'b11, 3'd5, 1, mk(24'h020200, 3'd0, 0, 4'b0000, 4'b0000, 0, 16'h0000)};
    vecs[10] = '{2'd3, 2'b10, 3'd5, 1, mk(24'h020200, 3'd0, 0, 4'b0000, 4'b0000, 0, 16'h0000)};
    vecs[11] = '{2'd3, 2'b01, 3'd1, 1, mk(24'h020200, 3'd1, 0, 4'b0000, 4'b0000, 0, 16'h0101)};
    vecs[12] = '{2'd3, 2'b10, 3'd1, 1, mk(24'h020200, 3'd1, 0, 4'b0000, 4'b0010, 0, 16'h0101)};
    vecs[13] = '{2'd3, 2'b10, 3'd1, 1, mk(24'h020200, 3'd1, 0, 4'b0000, 4'b0000, 0, 16'h0101)};
    vecs[14] = '{2'd0, 2'b00, 3'd1, 2, mk(24'h020200, 3'd1, 0, 4'b0000, 4'b0000, 0, 16'h0101)};
    vecs[15] = '{2'd0, 2'b00, 3'd1, 1, mk(24'h020201, 3'd1, 0, 4'b0000, 4'b0000, 1, 16'h0101)};
    vecs[16] = '{2'd0, 2'b00, 3'd1, 1, mk(24'h020201, 3'd1, 0, 4'b0000, 4'b0000, 0, 16'h0101)};
    vecs[17] = '{2'd1, 2'b00, 3'd1, 1, mk(24'h020200, 3'd1, 0, 4'b0000, 4'b0000, 0, 16'h0101)};
    vecs[18] = '{2'd0, 2'b00, 3'd1, 2, mk(24'h020200, 3'd1, 0, 4'b0000, 4'b0000, 0, 16'h0101)};
    vecs[19] = '{2'd0, 2'b00, 3'd1, 1, mk(24'h020201, 3'd1, 0, 4'b0000, 4'b0000, 1, 16'h0101)};

    for (int i = 0; i < 20; i++) begin
      expect_obs(vecs[i].exp);
      run(vecs[i].mode, vecs[i].btn, vecs[i].sel, vecs[i].ncyc);
      check_obs($sformatf("vec%0d", i));
    end

    // set 23:59:00 through the wrap points, then roll past midnight
    expect_obs(mk(24'h000200, 3'd1, 0, 4'b0000, 4'b0000, 0, 16'h0101));
    run(2'd1, 2'b10, 3'd1, 22);
    check_obs("set_hour_wrap");
    expect_obs(mk(24'h230000, 3'd1, 0, 4'b0000, 4'b0000, 0, 16'h0101));
    run(2'd1, 2'b10, 3'd1, 23);
    run(2'd1, 2'b01, 3'd1, 58);
    check_obs("set_min_wrap");
    expect_obs(mk(24'h235900, 3'd1, 0, 4'b0000, 4'b0000, 0, 16'h0101));
    run(2'd1, 2'b01, 3'd1, 59);
    check_obs("set_2359");
    expect_obs(mk(24'h235959, 3'd1, 0, 4'b0000, 4'b0000, 1, 16'h0101));
    run(2'd0, 2'b00, 3'd1, 177);
    check_obs("run_235959");
    expect_obs(mk(24'h000000, 3'd2, 0, 4'b0000, 4'b0000, 1, 16'h0101));
    run(2'd0, 2'b00, 3'd1, 3);
    check_obs("midnight_carry");

    // slot 2 alarm at 00:01, buzz for five ticks
    expect_obs(mk(24'h000000, 3'd2, 0, 4'b0000, 4'b0000, 0, 16'h0001));
    run(2'd2, 2'b01, 3'd2, 1);
    check_obs("set_alarm2");
    expect_obs(mk(24'h000000, 3'd2, 0, 4'b0000, 4'b0100, 0, 16'h0001));
    run(2'd3, 2'b10, 3'd2, 1);
    check_obs("enable_alarm2");
    expect_obs(mk(24'h000059, 3'd2, 0, 4'b0000, 4'b0100, 1, 16'h0001));
    run(2'd0, 2'b00, 3'd2, 177);
    check_obs("pre_alarm");
    expect_obs(mk(24'h000100, 3'd2, 1, 4'b0100, 4'b0100, 1, 16'h0001));
    run(2'd0, 2'b00, 3'd2, 3);
    check_obs("buzz_start");
    expect_obs(mk(24'h000104, 3'd2, 1, 4'b0100, 4'b0100, 1, 16'h0001));
    run(2'd0, 2'b00, 3'd2, 12);
    check_obs("buzz_hold");
    expect_obs(mk(24'h000105, 3'd2, 0, 4'b0000, 4'b0100, 1, 16'h0001));
    run(2'd0, 2'b00, 3'd2, 3);
    check_obs("buzz_end");

    // slots 0 and 3 together, slot 2 disabled, silenced by a button
    expect_obs(mk(24'h000105, 3'd2, 0, 4'b0000, 4'b0000, 0, 16'h0001));
    run(2'd3, 2'b10, 3'd2, 1);
    check_obs("disable_alarm2");
    run(2'd2, 2'b01, 3'd0, 1);
    run(2'd2, 2'b01, 3'd3, 1);
    run(2'd3, 2'b10, 3'd0, 1);
    expect_obs(mk(24'h000105, 3'd2, 0, 4'b0000, 4'b1001, 0, 16'h0001));
    run(2'd3, 2'b10, 3'd3, 1);
    check_obs("enable_0_3");
    expect_obs(mk(24'h000000, 3'd2, 0, 4'b0000, 4'b1001, 0, 16'h0001));
    run(2'd1, 2'b01, 3'd3, 59);
    check_obs("rewind_0000");
    expect_obs(mk(24'h000100, 3'd2, 1, 4'b1001, 4'b1001, 1, 16'h0001));
    run(2'd0, 2'b00, 3'd3, 180);
    check_obs("multi_hit");
    expect_obs(mk(24'h000102, 3'd2, 1, 4'b1001, 4'b1001, 1, 16'h0001));
    run(2'd0, 2'b00, 3'd3, 6);
    check_obs("multi_hold");
    expect_obs(mk(24'h000102, 3'd2, 0, 4'b0000, 4'b1001, 0, 16'h0001));
    run(2'd0, 2'b01, 3'd3, 1);
    check_obs("silence");
    expect_obs(mk(24'h000103, 3'd2, 0, 4'b0000, 4'b1001, 1, 16'h0001));
    run(2'd0, 2'b00, 3'd3, 2);
    check_obs("stay_silent");

    // asynchronous reset mid-buzz, mid-prescale
    run(2'd1, 2'b01, 3'd3, 59);
    expect_obs(mk(24'h000100, 3'd2, 1, 4'b1001, 4'b1001, 1, 16'h0001));
    run(2'd0, 2'b00, 3'd3, 180);
    check_obs("rebuzz");
    expect_obs(mk(24'h000101, 3'd2, 1, 4'b1001, 4'b1001, 0, 16'h0001));
    run(2'd0, 2'b00, 3'd3, 4);
    check_obs("mid_prescale");
    #3;
    rst = 1'b0;
    #1;
    expect_obs('0);
    check_obs("async_reset");
    @(posedge mclk);
    #1;
    expect_obs('0);
    check_obs("reset_held");
    rst = 1'b1;
    expect_obs(mk(24'h000001, 3'd0, 0, 4'b0000, 4'b0000, 1, 16'h0000));
    run(2'd0, 2'b00, 3'd3, 3);
    check_obs("restart_count");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
